// File: rtl/cw305_crypto_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cw305_crypto_ctrl_pkg
// Shared register map, identification value, status bit positions and FSM type
// Rev    : 1.0
// ============================================================================
package cw305_crypto_ctrl_pkg;

    localparam int c_ADDR_WIDTH    = 21;
    localparam int c_BYTECNT_SIZE  = 7;

    localparam int c_ADDR_IDENT     = 0;
    localparam int c_ADDR_KEY       = 1;
    localparam int c_ADDR_TEXTIN    = 2;
    localparam int c_ADDR_CIPHEROUT = 3;
    localparam int c_ADDR_GO        = 4;
    localparam int c_ADDR_STATUS    = 5;

    localparam logic [7:0] c_IDENT_VALUE = 8'h5C;

    localparam int c_ST_BUSY    = 0;
    localparam int c_ST_DONE    = 1;
    localparam int c_ST_TIMEOUT = 2;
    localparam int c_ST_WRERR   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_byte_mux.sv
`default_nettype none
// ============================================================================
// Module : reg_byte_mux
// Selects byte i_byte of a wide register; out-of-range bytes read as zero
// Rev    : 1.0
// ============================================================================
module reg_byte_mux #(
    parameter int WIDTH    = 128,
    parameter int BC_WIDTH = 7
) (
    input  logic [WIDTH-1:0]    i_data,
    input  logic [BC_WIDTH-1:0] i_byte,
    output logic [7:0]          o_byte
);

    localparam int NBYTES = WIDTH / 8;

    always_comb begin
        o_byte = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (i_byte == BC_WIDTH'(i)) begin
                o_byte = i_data[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cw305_crypto_ctrl.sv
`default_nettype none
// ============================================================================
// Module : cw305_crypto_ctrl
// USB register-bus controller: key/text load, GO sequencing, ciphertext capture
// Rev    : 1.0
// ============================================================================
module cw305_crypto_ctrl
    import cw305_crypto_ctrl_pkg::*;
#(
    parameter int pADDR_WIDTH   = c_ADDR_WIDTH,
    parameter int pBYTECNT_SIZE = c_BYTECNT_SIZE,
    parameter int pKEY_WIDTH    = 128,
    parameter int pTEXT_WIDTH   = 128,
    parameter int pTIMEOUT      = 65535
) (
    input  logic                               usb_clk,
    input  logic                               reset,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]           reg_bytecnt,
    input  logic [7:0]                         reg_datao,
    output logic [7:0]                         reg_datai,
    input  logic                               reg_read,
    input  logic                               reg_write,
    input  logic                               reg_addrvalid,
    output logic [pKEY_WIDTH-1:0]              crypto_key,
    output logic [pTEXT_WIDTH-1:0]             crypto_pt,
    output logic                               crypto_start,
    input  logic                               crypto_ready,
    input  logic                               crypto_done,
    input  logic [pTEXT_WIDTH-1:0]             crypto_ct,
    output logic                               trigger,
    output logic                               busy
);

    localparam int AW         = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int KEY_BYTES  = pKEY_WIDTH / 8;
    localparam int TEXT_BYTES = pTEXT_WIDTH / 8;
    localparam int CW         = $clog2(pTIMEOUT + 1);

    localparam logic [AW-1:0] c_A_IDENT  = AW'(c_ADDR_IDENT);
    localparam logic [AW-1:0] c_A_KEY    = AW'(c_ADDR_KEY);
    localparam logic [AW-1:0] c_A_TEXT   = AW'(c_ADDR_TEXTIN);
    localparam logic [AW-1:0] c_A_CT     = AW'(c_ADDR_CIPHEROUT);
    localparam logic [AW-1:0] c_A_GO     = AW'(c_ADDR_GO);
    localparam logic [AW-1:0] c_A_STATUS = AW'(c_ADDR_STATUS);
    localparam logic [CW-1:0] c_TO_LAST  = CW'(pTIMEOUT - 1);

    state_t                 r_state;
    logic [pKEY_WIDTH-1:0]  r_key;
    logic [pTEXT_WIDTH-1:0] r_pt;
    logic [pTEXT_WIDTH-1:0] r_ct;
    logic [CW-1:0]          r_cnt;
    logic [7:0]             r_datai;
    logic                   r_start;
    logic                   r_active;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_wr_err;

    logic       w_wr;
    logic       w_byte0;
    logic       w_go;
    logic       w_key_wr;
    logic       w_pt_wr;
    logic       w_st_wr;
    logic       w_expire;
    logic [7:0] w_status;
    logic [7:0] w_key_byte;
    logic [7:0] w_pt_byte;
    logic [7:0] w_ct_byte;
    logic       w_unused;

    // The adapter's read strobe is not needed: the read mux updates every edge.
    assign w_unused = reg_read;

    assign w_wr     = reg_write & reg_addrvalid;
    assign w_byte0  = (reg_bytecnt == '0);
    assign w_go     = w_wr && (reg_address == c_A_GO) && w_byte0 && reg_datao[0];
    assign w_key_wr = w_wr && (reg_address == c_A_KEY);
    assign w_pt_wr  = w_wr && (reg_address == c_A_TEXT);
    assign w_st_wr  = w_wr && (reg_address == c_A_STATUS) && w_byte0;
    assign w_expire = (r_cnt == c_TO_LAST);

    always_comb begin
        w_status               = 8'h00;
        w_status[c_ST_BUSY]    = r_active;
        w_status[c_ST_DONE]    = r_done;
        w_status[c_ST_TIMEOUT] = r_timeout;
        w_status[c_ST_WRERR]   = r_wr_err;
    end

    // Key/text stay frozen while an operation is in flight so the core sees stable inputs.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            r_key    <= '0;
            r_pt     <= '0;
            r_wr_err <= 1'b0;
        end else begin
            if (w_key_wr && !r_active) begin
                for (int i = 0; i < KEY_BYTES; i++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(i)) begin
                        r_key[8*i +: 8] <= reg_datao;
                    end
                end
            end
            if (w_pt_wr && !r_active) begin
                for (int i = 0; i < TEXT_BYTES; i++) begin
                    if (reg_bytecnt == pBYTECNT_SIZE'(i)) begin
                        r_pt[8*i +: 8] <= reg_datao;
                    end
                end
            end
            if ((w_key_wr || w_pt_wr) && r_active) begin
                r_wr_err <= 1'b1;
            end else if (w_st_wr && reg_datao[c_ST_WRERR]) begin
                r_wr_err <= 1'b0;
            end
        end
    end

    // W1C clears come first so a same-edge set further down takes priority.
    always_ff @(posedge usb_clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_active  <= 1'b0;
            r_cnt     <= '0;
            r_ct      <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_st_wr && reg_datao[c_ST_DONE]) begin
                r_done <= 1'b0;
            end
            if (w_st_wr && reg_datao[c_ST_TIMEOUT]) begin
                r_timeout <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_go) begin
                        r_state  <= ST_START;
                        r_start  <= 1'b1;
                        r_active <= 1'b1;
                        r_cnt    <= '0;
                        r_done   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_expire) begin
                        r_state   <= ST_IDLE;
                        r_start   <= 1'b0;
                        r_active  <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (crypto_ready) begin
                            r_state <= ST_WAIT;
                            r_start <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (crypto_done) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_ct     <= crypto_ct;
                        r_done   <= 1'b1;
                    end else if (w_expire) begin
                        r_state   <= ST_IDLE;
                        r_active  <= 1'b0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_start  <= 1'b0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    reg_byte_mux #(.WIDTH(pKEY_WIDTH), .BC_WIDTH(pBYTECNT_SIZE)) u_key_mux (
        .i_data (r_key),
        .i_byte (reg_bytecnt),
        .o_byte (w_key_byte)
    );

    reg_byte_mux #(.WIDTH(pTEXT_WIDTH), .BC_WIDTH(pBYTECNT_SIZE)) u_pt_mux (
        .i_data (r_pt),
        .i_byte (reg_bytecnt),
        .o_byte (w_pt_byte)
    );

    reg_byte_mux #(.WIDTH(pTEXT_WIDTH), .BC_WIDTH(pBYTECNT_SIZE)) u_ct_mux (
        .i_data (r_ct),
        .i_byte (reg_bytecnt),
        .o_byte (w_ct_byte)
    );

    always_ff @(posedge usb_clk) begin
        if (reset) begin
            r_datai <= 8'h00;
        end else begin
            case (reg_address)
                c_A_IDENT:  r_datai <= w_byte0 ? c_IDENT_VALUE : 8'h00;
                c_A_KEY:    r_datai <= w_key_byte;
                c_A_TEXT:   r_datai <= w_pt_byte;
                c_A_CT:     r_datai <= w_ct_byte;
                c_A_STATUS: r_datai <= w_byte0 ? w_status : 8'h00;
                default:    r_datai <= 8'h00;
            endcase
        end
    end

    assign reg_datai    = r_datai;
    assign crypto_key   = r_key;
    assign crypto_pt    = r_pt;
    assign crypto_start = r_start;
    assign trigger      = r_active;
    assign busy         = r_active;

endmodule
`default_nettype wire
